logic_rs_unit: RTL
==================

// Module: logic_rs_unit
// PURPOSE
//  Reservation station and result stage for the Tomasulo logic functional unit (AND/OR/XOR/NOR).
//  Accepts renamed ops from dispatch and snoops the CDB for pending operands.
//  Issues ready entries to the combinational 32-bit logic datapath and holds each result until the CDB arbiter grants it.
// PARAMETERS
//  RS_DEPTH    4   number of station entries, 2..8
//  TAG_W       4   CDB tag width
//  RS_TAG_BASE 4   tag of entry 0; entry i owns tag RS_TAG_BASE+i
// PORTS
//  CLK          in   1      clock, rising edge
//  RSTN         in   1      asynchronous, active-low reset
//  FLUSH        in   1      synchronous squash of all in-flight work
//  DISP_VALID   in   1      dispatch offers an op
//  DISP_READY   out  1      station can accept (registered: !full)
//  DISP_TAG     out  TAG_W  tag the offered op will own (lowest free entry)
//  DISP_OP      in   2      00 AND, 01 OR, 10 XOR, 11 NOR
//  DISP_RJ/RK   in   1      operand j/k value present
//  DISP_VJ/VK   in   32     operand value (valid when R=1)
//  DISP_QJ/QK   in   TAG_W  producer tag (valid when R=0)
//  CDB_VALID    in   1      broadcast valid
//  CDB_TAG      in   TAG_W  broadcast tag
//  CDB_DATA     in   32     broadcast value
//  RES_VALID    out  1      result pending for CDB
//  RES_TAG      out  TAG_W  result tag
//  RES_DATA     out  32     result value
//  CDB_GRANT    in   1      arbiter accepts result this cycle
// BEHAVIOUR
//  Reset: all entries invalid; RES_VALID=0, RES_TAG=0, RES_DATA=0; DISP_READY=1; DISP_TAG=RS_TAG_BASE.
//  Dispatch fire = DISP_VALID & DISP_READY. The op is written to the lowest-index free entry.
//  Snoop: every cycle, each valid entry with R=0 and Q==CDB_TAG under CDB_VALID loads V=CDB_DATA and sets R=1.
//  The same match also applies to operands being dispatched in that same cycle, so no broadcast is lost.
//  Issue eligibility: entry valid, RJ=RK=1, and result slot free (RES_VALID=0 or CDB_GRANT=1 this cycle).
//  Selection is fixed priority, lowest index first.
//  On issue, at the next edge: RES_DATA=f(op,VJ,VK), RES_TAG=entry tag, RES_VALID=1, and the entry is freed.
//  Latency: both operands ready at dispatch edge t -> issue in cycle t+1 -> RES_VALID at edge t+2.
//  Result hold: RES_* are stable while RES_VALID=1 and CDB_GRANT=0.
//  Grant with no new issue -> RES_VALID=0 next edge. Grant plus issue -> back-to-back result, no bubble.
//  CDB_GRANT while RES_VALID=0 is ignored.
//  Full: DISP_READY=0 when all entries valid. An entry freed by issue makes READY=1 only from the next cycle.
//  FLUSH: at the next edge all entries are invalid and RES_VALID=0. FLUSH overrides dispatch and issue in the same cycle.
//  RSTN low mid-operation clears the same state asynchronously.
//  No arithmetic; all ops are bitwise 32-bit. Tags compare over the full TAG_W.
// CONFIGURATION
//  LOGIC_RS_WAKEUP_BYPASS_EN defined:
//   - An entry whose last operand arrives on the CDB this cycle is issue-eligible in the same cycle.
//   - It issues using CDB_DATA directly, giving a wakeup-to-result latency of 1 edge.
//  Undefined:
//   - The entry is eligible only from the cycle after capture, giving 2 edges.
//  Result values are identical either way; only timing differs.
// STRUCTURE
//  tomasulo_pkg holds:
//   - op encodings LOGIC_AND/OR/XOR/NOR
//   - XLEN=32
//   - default TAG_W
//   - rs_entry struct {valid, op, rj, vj, qj, rk, vk, qk}
//  Sub-module logic_alu32 (combinational):
//   - built from and32/or32/xor32/nor32 with a 4:1 select on op
//   - one instance in the issue path
// TESTING
//  1. Reset release -> DISP_READY=1, DISP_TAG=4, RES_VALID=0, RES_DATA=0.
//  2. Dispatch NOR, VJ=FFFF0000, VK=0F0F0F0F, both ready, CDB_GRANT=1 -> RES_VALID at t+2,
//     RES_DATA=0000F0F0, RES_TAG=4.
//  3. Dispatch XOR, RJ=0 QJ=9, VK=000000FF; 3 cycles later CDB tag 9 data 0000FFFF
//     -> RES_DATA=0000FF00, at 1 edge with the macro defined and 2 edges without.
//  4. Dispatch with the CDB carrying QK's tag in the same cycle, AND with VJ=FFFFFFFF, CDB_DATA=12345678
//     -> RES_DATA=12345678; no deadlock.
//  5. Fill 4 entries with CDB_GRANT=0 -> DISP_READY=0, RES_* held stable for 10 cycles.
//     Then hold GRANT=1 -> the 4 results appear in consecutive cycles, tags 4,5,6,7.
//  6. FLUSH with 3 entries valid and RES_VALID=1 -> next edge RES_VALID=0, DISP_READY=1, DISP_TAG=4.
//     A later matching CDB broadcast produces no result.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared types for the Tomasulo logic unit: op encodings, datapath width and
// the reservation-station entry record.
package tomasulo_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DEF_TAG_W = 4;
  // Entry tags are stored zero-extended so any TAG_W up to this fits the record.
  localparam int unsigned TAG_W_MAX = 8;

  typedef enum logic [1:0] {
    LOGIC_AND = 2'b00,
    LOGIC_OR  = 2'b01,
    LOGIC_XOR = 2'b10,
    LOGIC_NOR = 2'b11
  } logic_op_e;

  typedef struct packed {
    logic                 valid;
    logic_op_e            op;
    logic                 rj;
    logic [XLEN-1:0]      vj;
    logic [TAG_W_MAX-1:0] qj;
    logic                 rk;
    logic [XLEN-1:0]      vk;
    logic [TAG_W_MAX-1:0] qk;
  } rs_entry_t;

endpackage

// File: rtl/logic_rs_unit_if.sv
// Dispatch, CDB snoop and result/grant signals of the logic reservation station.
interface logic_rs_unit_if #(
  parameter int unsigned TAG_W = tomasulo_pkg::DEF_TAG_W
);
  logic                          disp_valid;
  logic                          disp_ready;
  logic [TAG_W-1:0]              disp_tag;
  logic [1:0]                    disp_op;
  logic                          disp_rj;
  logic                          disp_rk;
  logic [tomasulo_pkg::XLEN-1:0] disp_vj;
  logic [tomasulo_pkg::XLEN-1:0] disp_vk;
  logic [TAG_W-1:0]              disp_qj;
  logic [TAG_W-1:0]              disp_qk;
  logic                          cdb_valid;
  logic [TAG_W-1:0]              cdb_tag;
  logic [tomasulo_pkg::XLEN-1:0] cdb_data;
  logic                          cdb_grant;
  logic                          res_valid;
  logic [TAG_W-1:0]              res_tag;
  logic [tomasulo_pkg::XLEN-1:0] res_data;

  modport slave (
    input  disp_valid, disp_op, disp_rj, disp_rk, disp_vj, disp_vk, disp_qj, disp_qk,
    input  cdb_valid, cdb_tag, cdb_data, cdb_grant,
    output disp_ready, disp_tag, res_valid, res_tag, res_data
  );

  modport master (
    output disp_valid, disp_op, disp_rj, disp_rk, disp_vj, disp_vk, disp_qj, disp_qk,
    output cdb_valid, cdb_tag, cdb_data, cdb_grant,
    input  disp_ready, disp_tag, res_valid, res_tag, res_data
  );
endinterface

// File: rtl/logic_alu32.sv
// Combinational 32-bit bitwise datapath: AND/OR/XOR/NOR with a 4:1 select on op.
module logic_alu32 import tomasulo_pkg::*; (
  input  logic_op_e       op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);
  logic [XLEN-1:0] and32, or32, xor32, nor32;

  assign and32 = a & b;
  assign or32  = a | b;
  assign xor32 = a ^ b;
  assign nor32 = ~(a | b);

  always_comb begin
    y = '0;
    unique case (op)
      LOGIC_AND: y = and32;
      LOGIC_OR:  y = or32;
      LOGIC_XOR: y = xor32;
      LOGIC_NOR: y = nor32;
    endcase
  end
endmodule

// File: rtl/logic_rs_unit.sv
// Reservation station + single result slot for the logic FU. Optional macro
// LOGIC_RS_WAKEUP_BYPASS_EN lets an entry woken by the CDB issue in the same cycle.
module logic_rs_unit import tomasulo_pkg::*; #(
  parameter int unsigned RS_DEPTH    = 4,
  parameter int unsigned TAG_W       = DEF_TAG_W,
  parameter int unsigned RS_TAG_BASE = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  logic_rs_unit_if.slave rs
);
  localparam int unsigned IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;

  rs_entry_t ent_q [RS_DEPTH];
  rs_entry_t ent_d [RS_DEPTH];
  rs_entry_t snp   [RS_DEPTH];
  rs_entry_t disp_ent;

  logic [RS_DEPTH-1:0]  rdy;
  logic [RS_DEPTH-1:0]  busy;
  logic                 iss_any, free_any, issue, disp_fire;
  logic [IDX_W-1:0]     iss_idx, free_idx;
  logic [TAG_W_MAX-1:0] cdb_tag_x;
  logic [XLEN-1:0]      alu_y;

  logic             res_valid_q, res_valid_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic [XLEN-1:0]  res_data_q, res_data_d;

  assign cdb_tag_x = TAG_W_MAX'(rs.cdb_tag);

  // Stored entries as they look after this cycle's CDB capture.
  always_comb begin
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      snp[i]  = ent_q[i];
      busy[i] = ent_q[i].valid;
      if (ent_q[i].valid && rs.cdb_valid) begin
        if (!ent_q[i].rj && ent_q[i].qj == cdb_tag_x) begin
          snp[i].rj = 1'b1;
          snp[i].vj = rs.cdb_data;
        end
        if (!ent_q[i].rk && ent_q[i].qk == cdb_tag_x) begin
          snp[i].rk = 1'b1;
          snp[i].vk = rs.cdb_data;
        end
      end
`ifdef LOGIC_RS_WAKEUP_BYPASS_EN
      rdy[i] = snp[i].valid && snp[i].rj && snp[i].rk;
`else
      rdy[i] = ent_q[i].valid && ent_q[i].rj && ent_q[i].rk;
`endif
    end
  end

  // Incoming op, with the same-cycle broadcast applied so it is never missed.
  always_comb begin
    disp_ent       = '0;
    disp_ent.valid = 1'b1;
    disp_ent.op    = logic_op_e'(rs.disp_op);
    disp_ent.rj    = rs.disp_rj;
    disp_ent.vj    = rs.disp_vj;
    disp_ent.qj    = TAG_W_MAX'(rs.disp_qj);
    disp_ent.rk    = rs.disp_rk;
    disp_ent.vk    = rs.disp_vk;
    disp_ent.qk    = TAG_W_MAX'(rs.disp_qk);
    if (rs.cdb_valid && !rs.disp_rj && disp_ent.qj == cdb_tag_x) begin
      disp_ent.rj = 1'b1;
      disp_ent.vj = rs.cdb_data;
    end
    if (rs.cdb_valid && !rs.disp_rk && disp_ent.qk == cdb_tag_x) begin
      disp_ent.rk = 1'b1;
      disp_ent.vk = rs.cdb_data;
    end
  end

  // Fixed priority, lowest index wins, for both issue and allocation.
  always_comb begin
    iss_any  = 1'b0;
    iss_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = int'(RS_DEPTH) - 1; i >= 0; i--) begin
      if (rdy[i]) begin
        iss_any = 1'b1;
        iss_idx = IDX_W'(i);
      end
      if (!busy[i]) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign issue     = iss_any && (!res_valid_q || rs.cdb_grant);
  assign disp_fire = rs.disp_valid && rs.disp_ready;

  logic_alu32 u_alu (
    .op (snp[iss_idx].op),
    .a  (snp[iss_idx].vj),
    .b  (snp[iss_idx].vk),
    .y  (alu_y)
  );

  always_comb begin
    for (int i = 0; i < int'(RS_DEPTH); i++) ent_d[i] = snp[i];
    res_valid_d = res_valid_q;
    res_tag_d   = res_tag_q;
    res_data_d  = res_data_q;
    if (issue) begin
      ent_d[iss_idx].valid = 1'b0;
      res_valid_d          = 1'b1;
      res_tag_d            = TAG_W'(RS_TAG_BASE + 32'(iss_idx));
      res_data_d           = alu_y;
    end else if (rs.cdb_grant) begin
      res_valid_d = 1'b0;
    end
    if (disp_fire) ent_d[free_idx] = disp_ent;
    if (flush) begin
      for (int i = 0; i < int'(RS_DEPTH); i++) ent_d[i].valid = 1'b0;
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RS_DEPTH); i++) ent_q[i] <= '0;
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
      res_data_q  <= '0;
    end else begin
      for (int i = 0; i < int'(RS_DEPTH); i++) ent_q[i] <= ent_d[i];
      res_valid_q <= res_valid_d;
      res_tag_q   <= res_tag_d;
      res_data_q  <= res_data_d;
    end
  end

  // Ready is a pure function of registered occupancy, so a slot freed by issue
  // only shows up as ready in the following cycle.
  assign rs.disp_ready = free_any;
  assign rs.disp_tag   = TAG_W'(RS_TAG_BASE + 32'(free_idx));
  assign rs.res_valid  = res_valid_q;
  assign rs.res_tag    = res_tag_q;
  assign rs.res_data   = res_data_q;
endmodule
